// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - sequences one 32-bit load/store as two timed 16-bit SRAM accesses
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   mem_read        load request level from the MEM stage (read wins over write)
//   mem_write       store request level from the MEM stage
//   address         byte address; BASE_ADDR is subtracted before halfword translation
//   wdata           store data
//   rdata           registered load result, low half then high half captured
//   ready           combinational; low while a request is pending and not yet complete
//   sram_addr       halfword address to the SRAM
//   sram_dq_out     write data to the SRAM, sram_dq_oe enables the pad driver
//   sram_dq_in      read data from the SRAM
//   sram_we_n       SRAM write enable, active low

module sram_mem_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          phase_last;
    logic          in_phase;
    logic [16:0]   word_in;
    logic [16:0]   word_q;
    logic [31:0]   wdata_q;
    logic [16:0]   cur_word;
    logic [31:0]   cur_wdata;

    // Word index wraps modulo 2^32 before the shift; only 17 bits reach the pins.
    assign word_in    = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign phase_last = (cnt == LAST);
    assign in_phase   = (state == RD_LO) || (state == RD_HI) ||
                        (state == WR_LO) || (state == WR_HI);

    // The output registers are loaded from the next state, so on the IDLE
    // edge the request inputs are used directly; afterwards the latched copy.
    assign cur_word  = (state == IDLE) ? word_in : word_q;
    assign cur_wdata = (state == IDLE) ? wdata   : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    state_next = RD_LO;
                end else if (mem_write) begin
                    state_next = WR_LO;
                end
                ready = !mem_read && !mem_write;
            end
            RD_LO: if (phase_last) state_next = RD_HI;
            RD_HI: if (phase_last) state_next = DONE;
            WR_LO: if (phase_last) state_next = WR_HI;
            WR_HI: if (phase_last) state_next = DONE;
            DONE: begin
                // Always return to IDLE so a request still held here is not re-issued.
                state_next = IDLE;
                ready      = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase counter restarts on every state change and counts cycles within a phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (in_phase) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && state_next != IDLE) begin
            word_q  <= word_in;
            wdata_q <= wdata;
        end
    end

    // Load data is sampled on the last cycle of each read phase, giving the
    // SRAM the full phase to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (phase_last && state == RD_LO) begin
            rdata[15:0] <= sram_dq_in;
        end else if (phase_last && state == RD_HI) begin
            rdata[31:16] <= sram_dq_in;
        end
    end

    // SRAM pins are registered so address, data and strobes change together.
    // Address and data hold their last value while the bus is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state_next)
                RD_LO: begin
                    sram_addr  <= {cur_word, 1'b0};
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
                RD_HI: begin
                    sram_addr  <= {cur_word, 1'b1};
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
                WR_LO: begin
                    sram_addr   <= {cur_word, 1'b0};
                    sram_dq_out <= cur_wdata[15:0];
                    sram_dq_oe  <= 1'b1;
                    sram_we_n   <= 1'b0;
                end
                WR_HI: begin
                    sram_addr   <= {cur_word, 1'b1};
                    sram_dq_out <= cur_wdata[31:16];
                    sram_dq_oe  <= 1'b1;
                    sram_we_n   <= 1'b0;
                end
                default: begin
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - scoreboard bench for sram_mem_controller

module tb_sram_mem_controller;

    localparam int N    = 2;
    localparam int BASE = 1024;

    typedef struct {
        bit          wr;
        logic [16:0] word;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in = 16'h0;
    logic        sram_we_n;

    // Latency-sweep instances share a single read stimulus.
    logic        l_rd;
    logic        l_wr = 1'b0;
    logic [31:0] l_addr = 32'd1024;
    logic [31:0] l_wdata = 32'h0;
    logic [15:0] l_dq = 16'h1234;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3, oe1, oe3, we1, we3;
    logic [17:0] sa1, sa3;
    logic [15:0] dqo1, dqo3;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    txn_t        q[$];
    logic [31:0] ref_mem [int];
    logic [15:0] sram_mem [int];

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_mem_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(l_rd), .mem_write(l_wr),
        .address(l_addr), .wdata(l_wdata), .rdata(rdata1), .ready(ready1),
        .sram_addr(sa1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
        .sram_dq_in(l_dq), .sram_we_n(we1)
    );

    sram_mem_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .mem_read(l_rd), .mem_write(l_wr),
        .address(l_addr), .wdata(l_wdata), .rdata(rdata3), .ready(ready3),
        .sram_addr(sa3), .sram_dq_out(dqo3), .sram_dq_oe(oe3),
        .sram_dq_in(l_dq), .sram_we_n(we3)
    );

    // Board SRAM model: write on a low strobe at the clock edge, read data
    // presented half a cycle after the address moves.
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[int'(sram_addr)] = sram_dq_out;
    end

    always @(negedge clk) begin
        sram_dq_in = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        longint d;
        d = longint'({32'h0, a}) - BASE;
        if (d < 0) d = d + 64'h1_0000_0000;
        return 17'((d / 4) % 131072);
    endfunction

    // Must be entered just after a rising edge; leaves just after one.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit flush);
        txn_t t;
        bit   seen;
        t.word = word_of(a);
        if (rd) begin
            t.wr   = 1'b0;
            t.data = ref_mem.exists(int'(t.word)) ? ref_mem[int'(t.word)] : 32'h0;
        end else begin
            t.wr   = 1'b1;
            t.data = d;
            ref_mem[int'(t.word)] = d;
        end
        q.push_back(t);
        mem_read  = rd;
        mem_write = wr;
        address   = a;
        wdata     = d;
        if (flush) begin
            @(posedge clk); #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            address   = $urandom;
            wdata     = $urandom;
        end
        seen = 1'b0;
        for (int i = 0; i < 4 * N + 10; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ready_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Monitor: an access is the run of ready-low cycles; the following
    // ready-high cycle is DONE, where the front of the scoreboard is retired.
    initial begin : monitor
        txn_t cur;
        bit   in_txn;
        bit   bus_ok;
        int   k;
        in_txn = 1'b0;
        bus_ok = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                in_txn = 1'b0;
            end else if (!in_txn) begin
                if (!ready) begin
                    if (q.size() == 0) begin
                        chk("queue_has_entry", 32'(q.size()), 32'd1);
                    end else begin
                        cur    = q[0];
                        in_txn = 1'b1;
                        k      = 0;
                        bus_ok = (sram_we_n === 1'b1) && (sram_dq_oe === 1'b0);
                    end
                end
            end else if (!ready) begin
                k++;
                if (k > 2 * N) begin
                    bus_ok = 1'b0;
                end else begin
                    if (sram_addr !== {cur.word, (k > N)}) bus_ok = 1'b0;
                    if (sram_we_n !== !cur.wr) bus_ok = 1'b0;
                    if (sram_dq_oe !== cur.wr) bus_ok = 1'b0;
                    if (cur.wr && sram_dq_out !== ((k > N) ? cur.data[31:16] : cur.data[15:0]))
                        bus_ok = 1'b0;
                end
            end else begin
                chk("ready_low_cycles", 32'(k + 1), 32'(2 * N + 1));
                chk("bus_sequence", 32'(bus_ok), 32'd1);
                if (cur.wr) begin
                    chk("sram_word", {sram_mem.exists(int'({cur.word, 1'b1})) ? sram_mem[int'({cur.word, 1'b1})] : 16'h0,
                                      sram_mem.exists(int'({cur.word, 1'b0})) ? sram_mem[int'({cur.word, 1'b0})] : 16'h0},
                        cur.data);
                end else begin
                    chk("rdata", rdata, cur.data);
                end
                void'(q.pop_front());
                in_txn = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int c1, c3, g, r;
        bit aux_ok, rd, wr, fl;
        logic [31:0] a;
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        address = 32'h0;
        wdata = 32'h0;
        l_rd = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        do_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        do_txn(1'b1, 1'b1, 32'd1024, 32'h55AA55AA, 1'b0);
        do_txn(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b1);
        do_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        do_txn(1'b0, 1'b1, 32'd1020, 32'h13579BDF, 1'b0);
        do_txn(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
        do_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r < 4) || (r == 8);
            wr = (r >= 4);
            fl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0)
                a = 32'(BASE) - 32'(4 * $urandom_range(1, 3)) + 32'($urandom_range(0, 3));
            else
                a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            do_txn(rd, wr, a, $urandom, fl);
            g = int'($urandom_range(0, 2));
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end

        // Latency sweep with one-cycle and three-cycle phases.
        c1 = 0;
        c3 = 0;
        aux_ok = 1'b1;
        l_rd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!ready1) c1++;
            if (!ready3) c3++;
            if (we1 !== 1'b1 || we3 !== 1'b1 || oe1 !== 1'b0 || oe3 !== 1'b0) aux_ok = 1'b0;
            if (i == 0) begin
                @(posedge clk); #1;
                l_rd = 1'b0;
            end
        end
        chk("n1_ready_low", 32'(c1), 32'd3);
        chk("n3_ready_low", 32'(c3), 32'd7);
        chk("sweep_bus_idle", 32'(aux_ok), 32'd1);
        chk("n1_rdata", rdata1, 32'h12341234);
        chk("n3_rdata", rdata3, 32'h12341234);
        chk("n1_last_addr", 32'(sa1), 32'h1);
        chk("n3_last_addr", 32'(sa3), 32'h1);
        chk("n1_dq_out", 32'(dqo1), 32'h0);
        chk("n3_dq_out", 32'(dqo3), 32'h0);

        // Reset in the middle of the high write phase.
        @(posedge clk); #1;
        mon_en = 1'b0;
        mem_write = 1'b1;
        address = 32'(BASE + 64);
        wdata = 32'hA5A5_5A5A;
        repeat (N + 1) @(posedge clk);
        #1;
        chk("we_n_in_wr_hi", 32'(sram_we_n), 32'd0);
        chk("addr_in_wr_hi", 32'(sram_addr), 32'd33);
        rst = 1'b1;
        mem_write = 1'b0;
        #1;
        chk("async_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("async_rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd1);
        chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_addr", 32'(sram_addr), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
